// File: rtl/forwarding_hazard_unit_if.sv
// Decode-stage bypass bus: pipeline stage descriptors in, per-operand bypass
// values, stall and the stall counter out.
interface forwarding_hazard_unit_if #(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
);
  logic [NUM_SRC*REG_AW-1:0] id_rs;
  logic [NUM_SRC-1:0]        id_rs_used;
  logic                      ex_valid;
  logic                      ex_we;
  logic [REG_AW-1:0]         ex_rd;
  logic                      mem_valid;
  logic                      mem_we;
  logic                      mem_read;
  logic [REG_AW-1:0]         mem_rd;
  logic [XLEN-1:0]           mem_alu_res;
  logic                      wb_valid;
  logic                      wb_we;
  logic                      wb_mem_read;
  logic [REG_AW-1:0]         wb_rd;
  logic [XLEN-1:0]           wb_alu_res;
  logic [XLEN-1:0]           wb_mem_data;
  logic [NUM_SRC*XLEN-1:0]   fwd_data;
  logic [NUM_SRC-1:0]        fwd_valid;
  logic                      stall;
  logic [CNT_W-1:0]          stall_count;

  modport master (
    output id_rs, id_rs_used,
    output ex_valid, ex_we, ex_rd,
    output mem_valid, mem_we, mem_read, mem_rd, mem_alu_res,
    output wb_valid, wb_we, wb_mem_read, wb_rd, wb_alu_res, wb_mem_data,
    input  fwd_data, fwd_valid, stall, stall_count
  );

  modport slave (
    input  id_rs, id_rs_used,
    input  ex_valid, ex_we, ex_rd,
    input  mem_valid, mem_we, mem_read, mem_rd, mem_alu_res,
    input  wb_valid, wb_we, wb_mem_read, wb_rd, wb_alu_res, wb_mem_data,
    output fwd_data, fwd_valid, stall, stall_count
  );
endinterface

// File: rtl/forwarding_hazard_unit.sv
// Operand bypass and hazard detection for the decode stage, with a short
// history of retired register writes and a saturating stall-cycle counter.
module forwarding_hazard_unit #(
  parameter int XLEN       = 32,
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int HIST_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  forwarding_hazard_unit_if.slave bus
);

  logic [XLEN-1:0]   wb_result;
  logic              hist_push;
  logic              stall_int;
  logic              hist_valid_reg [HIST_DEPTH];
  logic [REG_AW-1:0] hist_rd_reg    [HIST_DEPTH];
  logic [XLEN-1:0]   hist_data_reg  [HIST_DEPTH];
  logic [CNT_W-1:0]  stall_count_reg;

  wire  [NUM_SRC-1:0]      hazard_vec;
  wire  [NUM_SRC-1:0]      fwd_valid_vec;
  wire  [NUM_SRC*XLEN-1:0] fwd_data_vec;

  assign wb_result = bus.wb_mem_read ? bus.wb_mem_data : bus.wb_alu_res;
  assign hist_push = bus.wb_valid & bus.wb_we & (bus.wb_rd != '0);

  // Entry 0 is the most recent retired write; older entries shift down.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < HIST_DEPTH; k++) begin
        hist_valid_reg[k] <= 1'b0;
        hist_rd_reg[k]    <= '0;
        hist_data_reg[k]  <= '0;
      end
    end else if (hist_push) begin
      hist_valid_reg[0] <= 1'b1;
      hist_rd_reg[0]    <= bus.wb_rd;
      hist_data_reg[0]  <= wb_result;
      for (int k = 1; k < HIST_DEPTH; k++) begin
        hist_valid_reg[k] <= hist_valid_reg[k-1];
        hist_rd_reg[k]    <= hist_rd_reg[k-1];
        hist_data_reg[k]  <= hist_data_reg[k-1];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [REG_AW-1:0] rs;
      logic              active;
      logic              hazard;
      logic              fv;
      logic [XLEN-1:0]   fd;

      assign rs     = bus.id_rs[gi*REG_AW +: REG_AW];
      assign active = bus.id_rs_used[gi] & (rs != '0);

      // Youngest producer wins; a hazard in a younger stage masks older data.
      always_comb begin
        hazard = 1'b0;
        fv     = 1'b0;
        fd     = '0;
        if (active) begin
          if (bus.ex_valid && bus.ex_we && bus.ex_rd == rs) begin
            hazard = 1'b1;
          end else if (bus.mem_valid && bus.mem_we && bus.mem_rd == rs) begin
            if (bus.mem_read) begin
              hazard = 1'b1;
            end else begin
              fv = 1'b1;
              fd = bus.mem_alu_res;
            end
          end else if (bus.wb_valid && bus.wb_we && bus.wb_rd == rs) begin
            fv = 1'b1;
            fd = wb_result;
          end else begin
            // Walk oldest to youngest so the youngest hit is the one kept.
            for (int k = HIST_DEPTH - 1; k >= 0; k--) begin
              if (hist_valid_reg[k] && hist_rd_reg[k] == rs) begin
                fv = 1'b1;
                fd = hist_data_reg[k];
              end
            end
          end
        end
      end

      assign hazard_vec[gi]                 = hazard;
      assign fwd_valid_vec[gi]              = fv;
      assign fwd_data_vec[gi*XLEN +: XLEN]  = fd;
    end
  endgenerate

  assign stall_int     = |hazard_vec;
  assign bus.stall     = stall_int;
  assign bus.fwd_valid = fwd_valid_vec;
  assign bus.fwd_data  = fwd_data_vec;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count_reg <= '0;
    end else if (stall_int && stall_count_reg != '1) begin
      stall_count_reg <= stall_count_reg + 1'b1;
    end
  end

  assign bus.stall_count = stall_count_reg;

endmodule
